// File: rtl/register_dump_unit_pkg.sv
// ============================================================================
// Module  : reg_dump_pkg
// Brief   : Shared widths, sizes and FSM state encoding for the register dump
//           unit. Macro REG_DUMP_CHECKSUM_EN adds the CSUM state.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package reg_dump_pkg;

  localparam int REG_COUNT = 32;
  localparam int DATA_W    = 32;
  localparam int IDX_W     = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_DONE = 3'd3
`ifdef REG_DUMP_CHECKSUM_EN
    ,
    ST_CSUM = 3'd4
`endif
  } state_t;

endpackage

`default_nettype wire

// File: rtl/register_dump_unit_if.sv
// ============================================================================
// Module  : register_dump_unit_if
// Brief   : Register-file read port, dump beat stream and status of the dump unit.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface register_dump_unit_if;
  import reg_dump_pkg::*;

  logic              start;
  logic [IDX_W-1:0]  Read_reg;
  logic [DATA_W-1:0] Read_data;
  logic [DATA_W-1:0] dump_data;
  logic [IDX_W-1:0]  dump_index;
  logic              dump_valid;
  logic              dump_ready;
  logic              dump_last;
  logic              busy;
  logic              done;

  // master is the dump unit itself; slave is the register file plus consumer
  modport master (
    input  start, Read_data, dump_ready,
    output Read_reg, dump_data, dump_index, dump_valid, dump_last, busy, done
  );

  modport slave (
    output start, Read_data, dump_ready,
    input  Read_reg, dump_data, dump_index, dump_valid, dump_last, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/register_dump_unit_xor_acc.sv
// ============================================================================
// Module  : reg_dump_xor_acc
// Brief   : Running XOR of accepted dump beats; clear has priority over enable.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module reg_dump_xor_acc
  import reg_dump_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              clear,
  input  wire logic              enable,
  input  wire logic [DATA_W-1:0] data,
  output logic      [DATA_W-1:0] sum
);

  logic [DATA_W-1:0] sum_q;
  logic [DATA_W-1:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear) begin
      sum_d = '0;
    end else if (enable) begin
      sum_d = sum_q ^ data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

`default_nettype wire

// File: rtl/register_dump_unit.sv
// ============================================================================
// Module  : register_dump_unit
// Brief   : Walks register indices FIRST_REG..LAST_REG, emitting one valid/ready
//           beat per register. REG_DUMP_CHECKSUM_EN appends an XOR beat.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module register_dump_unit
  import reg_dump_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
)(
  input  wire logic              clk,
  input  wire logic              reset,
  register_dump_unit_if.master   dif
);

  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(FIRST_REG);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST_REG);

  generate
    if (FIRST_REG > LAST_REG || FIRST_REG < 0 || LAST_REG >= REG_COUNT) begin : g_bad_range
      $error("register_dump_unit: illegal FIRST_REG/LAST_REG range");
    end
  endgenerate

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] dump_data_q, dump_data_d;
  logic [IDX_W-1:0]  dump_index_q, dump_index_d;
  logic              dump_last_q, dump_last_d;

`ifdef REG_DUMP_CHECKSUM_EN
  logic              acc_clr;
  logic              acc_en;
  logic [DATA_W-1:0] acc_sum;

  reg_dump_xor_acc u_xor_acc (
    .clk    (clk),
    .reset  (reset),
    .clear  (acc_clr),
    .enable (acc_en),
    .data   (dump_data_q),
    .sum    (acc_sum)
  );
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    dump_data_d  = dump_data_q;
    dump_index_d = dump_index_q;
    dump_last_d  = dump_last_q;
`ifdef REG_DUMP_CHECKSUM_EN
    acc_clr      = 1'b0;
    acc_en       = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (dif.start) begin
          idx_d   = FIRST_IDX;
          state_d = ST_LOAD;
`ifdef REG_DUMP_CHECKSUM_EN
          acc_clr = 1'b1;
`endif
        end
      end
      ST_LOAD: begin
        dump_data_d  = dif.Read_data;
        dump_index_d = idx_q;
`ifdef REG_DUMP_CHECKSUM_EN
        dump_last_d  = 1'b0;
`else
        dump_last_d  = (idx_q == LAST_IDX);
`endif
        state_d      = ST_SEND;
      end
      ST_SEND: begin
        if (dif.dump_ready) begin
`ifdef REG_DUMP_CHECKSUM_EN
          acc_en = 1'b1;
`endif
          if (idx_q == LAST_IDX) begin
`ifdef REG_DUMP_CHECKSUM_EN
            // Accumulator updates on this same edge, so fold the final beat in here
            state_d      = ST_CSUM;
            dump_data_d  = acc_sum ^ dump_data_q;
            dump_index_d = '0;
            dump_last_d  = 1'b1;
`else
            state_d      = ST_DONE;
`endif
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = ST_LOAD;
          end
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      ST_CSUM: begin
        if (dif.dump_ready) begin
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      dump_data_q  <= '0;
      dump_index_q <= '0;
      dump_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      dump_data_q  <= dump_data_d;
      dump_index_q <= dump_index_d;
      dump_last_q  <= dump_last_d;
    end
  end

  assign dif.Read_reg   = idx_q;
  assign dif.dump_data  = dump_data_q;
  assign dif.dump_index = dump_index_q;
  assign dif.dump_last  = dump_last_q;
`ifdef REG_DUMP_CHECKSUM_EN
  assign dif.dump_valid = (state_q == ST_SEND) || (state_q == ST_CSUM);
`else
  assign dif.dump_valid = (state_q == ST_SEND);
`endif
  assign dif.busy       = (state_q != ST_IDLE);
  assign dif.done       = (state_q == ST_DONE);

endmodule

`default_nettype wire
